// File: rtl/usbpd_pkg.sv
// Shared definitions for the USB-PD protocol-layer receiver.
//   rx_state_t        : receiver state machine encoding
//   sop_t             : SOP* channel codes carried in the frame-type byte
//   ALERT_*           : bit positions inside the 16-bit ALERT register
//   HDR_*             : field positions inside the two message-header bytes
//   is_soft_reset()   : decodes a Soft_Reset control message from header fields
package usbpd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECV,
    ST_CHECK,
    ST_SEND_GCRC,
    ST_REPORT,
    ST_DISCARD
  } rx_state_t;

  typedef enum logic [1:0] {
    SOP_DEFAULT = 2'd0,
    SOP_PRIME   = 2'd1,
    SOP_DPRIME  = 2'd2,
    SOP_DEBUG   = 2'd3
  } sop_t;

  localparam int ALERT_RX_STATUS     = 2;
  localparam int ALERT_RX_HARD_RESET = 3;
  localparam int ALERT_TX_DISCARDED  = 5;
  localparam int ALERT_RX_OVERFLOW   = 10;

  // Header low byte: [4:0] message type.
  // Header high byte: [3:1] MessageID, [6:4] number of data objects.
  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_MSGID_LSB = 1;
  localparam int HDR_NDO_LSB   = 4;

  localparam logic [4:0] MSG_TYPE_SOFT_RESET = 5'h0D;

  function automatic logic is_soft_reset(input logic [4:0] msg_type,
                                         input logic [2:0] num_data_objs);
    return (msg_type == MSG_TYPE_SOFT_RESET) && (num_data_objs == 3'd0);
  endfunction

endpackage

// File: rtl/usbpd_msgid_table.sv
// Per-SOP* MessageID table used for duplicate-message detection.
//   CLK, reset          : clock, synchronous active-high reset (all entries invalid)
//   lookup_sop/msgid    : query; hit=1 when the entry for lookup_sop is valid and
//                         holds lookup_msgid
//   wr, wr_sop, wr_msgid: store msgid for wr_sop and mark it valid
//   clr_one             : invalidate entry wr_sop (applied after a same-cycle store)
//   clr_all             : invalidate every entry
module usbpd_msgid_table #(
  parameter int NUM_SOP = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] lookup_sop,
  input  logic [2:0] lookup_msgid,
  output logic       hit,
  input  logic       wr,
  input  logic [1:0] wr_sop,
  input  logic [2:0] wr_msgid,
  input  logic       clr_one,
  input  logic       clr_all
);

  logic [NUM_SOP-1:0] valid_q;
  logic [2:0]         id_q [NUM_SOP];

  always_ff @(posedge CLK) begin
    if (reset || clr_all) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SOP; i++) id_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SOP; i++) begin
        if (wr_sop == i[1:0]) begin
          if (wr) begin
            valid_q[i] <= 1'b1;
            id_q[i]    <= wr_msgid;
          end
          // Later assignment wins: a store followed by invalidate leaves it invalid.
          if (clr_one) valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SOP; i++) begin
      if ((lookup_sop == i[1:0]) && valid_q[i] && (id_q[i] == lookup_msgid)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/usbpd_rx_prl.sv
// USB-PD protocol-layer receiver. Takes the PHY byte stream, writes
// frame-type + message bytes into the RX buffer, requests GoodCRC, filters
// duplicates per SOP* channel and reports through sticky W1C ALERT bits.
//   CLK, reset                : clock, synchronous active-high reset
//   start                     : enables reception (leaves IDLE, returns from WAIT when low)
//   rx_sof/rx_sop_type        : frame start strobe and its SOP* channel
//   rx_valid/rx_data          : received byte strobe and byte (header LSB first)
//   rx_eof/rx_crc_ok          : frame end strobe and PHY CRC verdict
//   hard_reset_in/cable_reset_in : link resets, abort everything
//   tx_active                 : transmitter busy; a colliding message is discarded
//   gcrc_done                 : PHY finished the GoodCRC transmission
//   alert_clr                 : write-1-to-clear mask for alert
//   alert                     : [2] RX_STATUS [3] RX_HARD_RESET [5] TX_DISCARDED [10] RX_OVERFLOW
//   byte_count                : buffered bytes of the last reported message
//   wr_en/wr_addr/wr_data     : RX buffer write port
//   gcrc_req/gcrc_msgid/gcrc_sop : GoodCRC request and its contents
// Handshakes: rx_sof/rx_valid/rx_eof and wr_en are single-cycle strobes with no
// back-pressure; gcrc_req is a level held until gcrc_done is seen (or timeout).
// All outputs are registered: inputs in cycle N appear on outputs after edge N.
// The current state is visible on the internal signal `state`.
module usbpd_rx_prl
  import usbpd_pkg::*;
#(
  parameter int         MAX_BYTES    = 31,
  parameter int         NUM_SOP      = 3,
  parameter logic [7:0] ADDR_BASE    = 8'h31,
  parameter int         GCRC_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_sof,
  input  logic [1:0]  rx_sop_type,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_eof,
  input  logic        rx_crc_ok,
  input  logic        hard_reset_in,
  input  logic        cable_reset_in,
  input  logic        tx_active,
  input  logic        gcrc_done,
  input  logic [15:0] alert_clr,
  output logic [15:0] alert,
  output logic [7:0]  byte_count,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        gcrc_req,
  output logic [2:0]  gcrc_msgid,
  output logic [1:0]  gcrc_sop
);

  localparam logic [7:0]  MAX_IDX  = 8'(MAX_BYTES);
  localparam logic [15:0] TMR_LAST = 16'(GCRC_TIMEOUT - 1);

  rx_state_t   state, state_n;
  logic [7:0]  idx_q, idx_n;
  logic [2:0]  msgid_q, msgid_n;
  logic [1:0]  sop_q, sop_n;
  logic [4:0]  type_q, type_n;
  logic [2:0]  ndo_q, ndo_n;
  logic        crc_q, crc_n;
  logic        ovf_q, ovf_n;
  logic [15:0] tmr_q, tmr_n;
  logic        tx_active_q;

  logic        wr_en_n;
  logic [7:0]  wr_addr_n, wr_data_n;
  logic [15:0] alert_set;
  logic        bc_load;
  logic        tbl_wr, tbl_clr_one, tbl_clr_all, tbl_hit;
  logic        sop_ok;

  assign sop_ok = (32'(rx_sop_type) < NUM_SOP);

  usbpd_msgid_table #(.NUM_SOP(NUM_SOP)) u_msgid_table (
    .CLK          (CLK),
    .reset        (reset),
    .lookup_sop   (sop_q),
    .lookup_msgid (msgid_q),
    .hit          (tbl_hit),
    .wr           (tbl_wr),
    .wr_sop       (sop_q),
    .wr_msgid     (msgid_q),
    .clr_one      (tbl_clr_one),
    .clr_all      (tbl_clr_all)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx_q;
    msgid_n     = msgid_q;
    sop_n       = sop_q;
    type_n      = type_q;
    ndo_n       = ndo_q;
    crc_n       = crc_q;
    ovf_n       = ovf_q;
    tmr_n       = tmr_q;
    wr_en_n     = 1'b0;
    wr_addr_n   = '0;
    wr_data_n   = '0;
    alert_set   = '0;
    bc_load     = 1'b0;
    tbl_wr      = 1'b0;
    tbl_clr_one = 1'b0;
    tbl_clr_all = 1'b0;

    case (state)
      ST_IDLE: if (start) state_n = ST_WAIT;

      ST_WAIT: begin
        if (!start) begin
          state_n = ST_IDLE;
        end else if (rx_sof && sop_ok) begin
          if (alert[ALERT_RX_STATUS]) begin
            // Previous message not yet read out: refuse the new one.
            alert_set[ALERT_RX_OVERFLOW] = 1'b1;
            state_n = ST_DISCARD;
          end else begin
            state_n   = ST_RECV;
            wr_en_n   = 1'b1;
            wr_addr_n = ADDR_BASE;
            wr_data_n = {6'b0, rx_sop_type};
            idx_n     = 8'd1;
            sop_n     = rx_sop_type;
            msgid_n   = '0;
            type_n    = '0;
            ndo_n     = '0;
            ovf_n     = 1'b0;
          end
        end
      end

      ST_RECV: begin
        if (tx_active && !tx_active_q) begin
          alert_set[ALERT_TX_DISCARDED] = 1'b1;
          state_n = ST_DISCARD;
        end else begin
          if (rx_valid) begin
            if (idx_q == MAX_IDX) begin
              alert_set[ALERT_RX_OVERFLOW] = 1'b1;
              ovf_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = ADDR_BASE + idx_q;
              wr_data_n = rx_data;
              idx_n     = idx_q + 8'd1;
              if (idx_q == 8'd1) type_n = rx_data[HDR_TYPE_LSB +: 5];
              if (idx_q == 8'd2) begin
                msgid_n = rx_data[HDR_MSGID_LSB +: 3];
                ndo_n   = rx_data[HDR_NDO_LSB +: 3];
              end
            end
          end
          if (rx_eof) begin
            crc_n   = rx_crc_ok;
            state_n = ovf_n ? ST_DISCARD : ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (!crc_q || (idx_q < 8'd3)) begin
          state_n = ST_WAIT;
        end else if (tx_active) begin
          alert_set[ALERT_TX_DISCARDED] = 1'b1;
          state_n = ST_DISCARD;
        end else begin
          tmr_n   = '0;
          state_n = ST_SEND_GCRC;
        end
      end

      ST_SEND_GCRC: begin
        if (gcrc_done) begin
          state_n = tbl_hit ? ST_WAIT : ST_REPORT;
        end else if (tmr_q == TMR_LAST) begin
          state_n = ST_WAIT;
        end else begin
          tmr_n = tmr_q + 16'd1;
        end
      end

      ST_REPORT: begin
        bc_load     = 1'b1;
        tbl_wr      = 1'b1;
        tbl_clr_one = is_soft_reset(type_q, ndo_q);
        alert_set[ALERT_RX_STATUS] = 1'b1;
        state_n = ST_WAIT;
      end

      ST_DISCARD: state_n = ST_WAIT;

      default: state_n = ST_IDLE;
    endcase

    // Link resets override whatever the state machine decided this cycle.
    if (hard_reset_in || cable_reset_in) begin
      state_n     = ST_WAIT;
      wr_en_n     = 1'b0;
      bc_load     = 1'b0;
      tbl_wr      = 1'b0;
      tbl_clr_one = 1'b0;
      tbl_clr_all = 1'b1;
      if (hard_reset_in) alert_set[ALERT_RX_HARD_RESET] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      msgid_q     <= '0;
      sop_q       <= '0;
      type_q      <= '0;
      ndo_q       <= '0;
      crc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tmr_q       <= '0;
      tx_active_q <= 1'b0;
      alert       <= '0;
      byte_count  <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      gcrc_req    <= 1'b0;
      gcrc_msgid  <= '0;
      gcrc_sop    <= '0;
    end else begin
      state       <= state_n;
      idx_q       <= idx_n;
      msgid_q     <= msgid_n;
      sop_q       <= sop_n;
      type_q      <= type_n;
      ndo_q       <= ndo_n;
      crc_q       <= crc_n;
      ovf_q       <= ovf_n;
      tmr_q       <= tmr_n;
      tx_active_q <= tx_active;
      alert       <= (alert & ~alert_clr) | alert_set;
      // A report in the same cycle as a clear keeps the new count.
      if (bc_load) byte_count <= idx_q;
      else if (alert_clr[ALERT_RX_STATUS]) byte_count <= '0;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      gcrc_req    <= (state_n == ST_SEND_GCRC);
      gcrc_msgid  <= (state_n == ST_SEND_GCRC) ? msgid_q : 3'd0;
      gcrc_sop    <= (state_n == ST_SEND_GCRC) ? sop_q : 2'd0;
    end
  end

endmodule

// File: tb/tb_usbpd_rx_prl.sv
module tb_usbpd_rx_prl;

  localparam int         MAX_BYTES    = 31;
  localparam int         GCRC_TIMEOUT = 64;
  localparam logic [7:0] ADDR_BASE    = 8'h31;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        rx_sof;
  logic [1:0]  rx_sop_type;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_eof;
  logic        rx_crc_ok;
  logic        hard_reset_in;
  logic        cable_reset_in;
  logic        tx_active;
  logic        gcrc_done;
  logic [15:0] alert_clr;
  logic [15:0] alert;
  logic [7:0]  byte_count;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        gcrc_req;
  logic [2:0]  gcrc_msgid;
  logic [1:0]  gcrc_sop;

  usbpd_rx_prl #(
    .MAX_BYTES    (MAX_BYTES),
    .NUM_SOP      (3),
    .ADDR_BASE    (ADDR_BASE),
    .GCRC_TIMEOUT (GCRC_TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .start          (start),
    .rx_sof         (rx_sof),
    .rx_sop_type    (rx_sop_type),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_eof         (rx_eof),
    .rx_crc_ok      (rx_crc_ok),
    .hard_reset_in  (hard_reset_in),
    .cable_reset_in (cable_reset_in),
    .tx_active      (tx_active),
    .gcrc_done      (gcrc_done),
    .alert_clr      (alert_clr),
    .alert          (alert),
    .byte_count     (byte_count),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .gcrc_req       (gcrc_req),
    .gcrc_msgid     (gcrc_msgid),
    .gcrc_sop       (gcrc_sop)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];   // expected RX buffer writes {addr, data}
  int          total;
  int          bad;
  logic        req_seen;

  typedef struct {
    logic        clr;      // clear all alerts before the frame
    logic [1:0]  sop;
    int          nb;       // header + data bytes sent
    logic [2:0]  id;
    logic [4:0]  mtype;
    logic [2:0]  ndo;
    logic        crc;
    logic        tx_eof;   // raise tx_active with rx_eof
    logic        done;     // answer gcrc_req with gcrc_done
    logic [15:0] rep_clr;  // alert_clr driven in the REPORT cycle
    logic        wr_ok;    // frame is expected to be written to the buffer
    logic        exp_req;
    logic [7:0]  exp_bc;
    logic [15:0] exp_al;
  } row_t;

  row_t rows[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample registered outputs just after the edge and consume writes.
  task automatic tick();
    logic [15:0] e;
    @(posedge CLK);
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got %0h expected no write", {wr_addr, wr_data});
      end else begin
        e = exp_q.pop_front();
        check("wr", {16'b0, wr_addr, wr_data}, {16'b0, e});
      end
    end
    if (gcrc_req === 1'b1) req_seen = 1'b1;
  endtask

  task automatic clear_alerts();
    alert_clr = 16'hFFFF;
    tick();
    alert_clr = 16'h0000;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input row_t r);
    logic [7:0] b;
    rx_sof      = 1'b1;
    rx_sop_type = r.sop;
    if (r.wr_ok) exp_q.push_back({ADDR_BASE, 6'b0, r.sop});
    tick();
    rx_sof = 1'b0;
    for (int i = 0; i < r.nb; i++) begin
      if (i == 0)      b = {3'b0, r.mtype};
      else if (i == 1) b = {1'b0, r.ndo, r.id, 1'b0};
      else             b = 8'($urandom_range(0, 255));
      rx_valid = 1'b1;
      rx_data  = b;
      if (r.wr_ok && (i < MAX_BYTES - 1)) exp_q.push_back({8'(ADDR_BASE + 8'(i) + 8'd1), b});
      tick();
    end
    rx_valid  = 1'b0;
    rx_eof    = 1'b1;
    rx_crc_ok = r.crc;
    tx_active = r.tx_eof;
    tick();
    rx_eof    = 1'b0;
    rx_crc_ok = 1'b0;
    tx_active = 1'b0;
  endtask

  task automatic run_row(input string tag, input row_t r);
    if (r.clr) clear_alerts();
    req_seen = 1'b0;
    send_frame(r);
    repeat (4) tick();
    check({tag, "_req"}, {31'b0, req_seen}, {31'b0, r.exp_req});
    if (req_seen) begin
      check({tag, "_gmsgid"}, {29'b0, gcrc_msgid}, {29'b0, r.id});
      check({tag, "_gsop"}, {30'b0, gcrc_sop}, {30'b0, r.sop});
      if (r.done) begin
        repeat (5) tick();
        gcrc_done = 1'b1;
        tick();
        gcrc_done = 1'b0;
        alert_clr = r.rep_clr;
        tick();
        alert_clr = 16'h0000;
      end else begin
        repeat (GCRC_TIMEOUT + 4) tick();
        check({tag, "_timeout_req"}, {31'b0, gcrc_req}, 32'd0);
      end
    end
    repeat (3) tick();
    check({tag, "_alert"}, {16'b0, alert}, {16'b0, r.exp_al});
    check({tag, "_bc"}, {24'b0, byte_count}, {24'b0, r.exp_bc});
    check({tag, "_wrq"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    row_t r;
    total = 0;
    bad   = 0;
    req_seen = 1'b0;
    reset = 1'b1; start = 1'b0; rx_sof = 1'b0; rx_sop_type = 2'd0; rx_valid = 1'b0;
    rx_data = 8'd0; rx_eof = 1'b0; rx_crc_ok = 1'b0; hard_reset_in = 1'b0;
    cable_reset_in = 1'b0; tx_active = 1'b0; gcrc_done = 1'b0; alert_clr = 16'h0000;

    //                clr   sop   nb  id    type   ndo   crc   txe   done  rep_clr  wr_ok req   bc     alert
    rows[0]  = '{1'b0, 2'd0, 6,  3'd1, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd7, 16'h0004};
    rows[1]  = '{1'b1, 2'd0, 6,  3'd1, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd0, 16'h0000};
    rows[2]  = '{1'b0, 2'd1, 6,  3'd1, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd7, 16'h0004};
    rows[3]  = '{1'b0, 2'd0, 6,  3'd2, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd7, 16'h0404};
    rows[4]  = '{1'b1, 2'd0, 31, 3'd2, 5'h01, 3'd7, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0400};
    rows[5]  = '{1'b1, 2'd0, 4,  3'd3, 5'h01, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000};
    rows[6]  = '{1'b1, 2'd0, 1,  3'd0, 5'h01, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000};
    rows[7]  = '{1'b1, 2'd3, 6,  3'd1, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000};
    rows[8]  = '{1'b1, 2'd2, 2,  3'd4, 5'h01, 3'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0020};
    rows[9]  = '{1'b1, 2'd2, 2,  3'd4, 5'h01, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd0, 16'h0000};
    rows[10] = '{1'b1, 2'd2, 2,  3'd4, 5'h01, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd3, 16'h0004};
    rows[11] = '{1'b1, 2'd2, 2,  3'd5, 5'h0D, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd3, 16'h0004};
    rows[12] = '{1'b1, 2'd2, 2,  3'd5, 5'h0D, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd3, 16'h0004};
    rows[13] = '{1'b1, 2'd1, 6,  3'd2, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 8'd7, 16'h0004};
    rows[14] = '{1'b1, 2'd1, 6,  3'd2, 5'h01, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'd0, 16'h0000};

    repeat (3) tick();
    check("rst_alert", {16'b0, alert}, 32'd0);
    check("rst_bc", {24'b0, byte_count}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_gcrc_req", {31'b0, gcrc_req}, 32'd0);
    reset = 1'b0;
    start = 1'b1;
    repeat (2) tick();

    for (int n = 0; n < 15; n++) run_row($sformatf("r%0d", n), rows[n]);

    // Overflow alert cleared by its own W1C bit.
    run_row("ovf", rows[4]);
    alert_clr = 16'h0400;
    tick();
    alert_clr = 16'h0000;
    check("ovf_clr_alert", {16'b0, alert}, 32'd0);

    // Hard reset mid-frame forgets stored MessageIDs.
    r = rows[0];
    r.clr = 1'b1;
    r.id  = 3'd6;
    run_row("hr_pre", r);
    clear_alerts();
    req_seen    = 1'b0;
    rx_sof      = 1'b1;
    rx_sop_type = 2'd0;
    exp_q.push_back({ADDR_BASE, 8'h00});
    tick();
    rx_sof   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    exp_q.push_back({8'h32, 8'h01});
    tick();
    rx_data = {1'b0, 3'd1, 3'd6, 1'b0};
    exp_q.push_back({8'h33, rx_data});
    tick();
    rx_valid      = 1'b0;
    hard_reset_in = 1'b1;
    tick();
    hard_reset_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i + 8'hA0);
      tick();
    end
    rx_valid  = 1'b0;
    rx_eof    = 1'b1;
    rx_crc_ok = 1'b1;
    tick();
    rx_eof    = 1'b0;
    rx_crc_ok = 1'b0;
    repeat (6) tick();
    check("hr_req", {31'b0, req_seen}, 32'd0);
    check("hr_alert", {16'b0, alert}, 32'h0008);
    check("hr_wrq", exp_q.size(), 32'd0);
    run_row("hr_post", r);

    // Synchronous reset while a GoodCRC request is outstanding.
    clear_alerts();
    cable_reset_in = 1'b1;
    tick();
    cable_reset_in = 1'b0;
    hard_reset_in  = 1'b1;
    tick();
    hard_reset_in  = 1'b0;
    r = rows[0];
    r.id = 3'd7;
    req_seen = 1'b0;
    send_frame(r);
    repeat (3) tick();
    check("rs_req_before", {31'b0, gcrc_req}, 32'd1);
    check("rs_alert_before", {16'b0, alert}, 32'h0008);
    reset = 1'b1;
    tick();
    check("rs_alert", {16'b0, alert}, 32'd0);
    check("rs_bc", {24'b0, byte_count}, 32'd0);
    check("rs_wr", {22'b0, wr_en, wr_addr, wr_data}, 32'd0);
    check("rs_gcrc", {26'b0, gcrc_req, gcrc_msgid, gcrc_sop}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("end_wrq", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
